// File: rtl/physics_pkg.sv
// physics_pkg: shared definitions for the physics divide arbiter.
//   state_t    - arbiter FSM encoding (IDLE=0, LOAD=1, DIV=2, DONE=3)
//   DEF_*      - default requester count and operand widths
//   FRAC_BITS  - fractional bits of the 16.32 fixed-point force/quotient format
package physics_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_NREQ  = 4;   // 2 players x (x, y) axis
    localparam int DEF_DW    = 48;  // signed dividend / quotient width
    localparam int DEF_VW    = 32;  // unsigned divisor (mass) width
    localparam int FRAC_BITS = 32;  // 16.32 fixed point

endpackage

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned DW / VW restoring divider, one quotient bit
// per clock, MSB first.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   start        - load operands; iteration begins on the following edge
//   dividend     - unsigned dividend, sampled on start
//   divisor      - unsigned divisor (non-zero), sampled on start
//   done         - high during the cycle whose rising edge computes the last
//                  quotient bit; quotient is final from the next cycle on
//   quotient     - quotient register (holds dividend bits still to be consumed
//                  while running)
module seq_restoring_divider #(
    parameter int DW = 48,
    parameter int VW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int CW = $clog2(DW);

    logic [VW-1:0] rem;        // partial remainder, always < divisor
    logic [VW-1:0] dvs;
    logic [DW-1:0] shreg;      // dividend bits shift out the top, quotient bits in the bottom
    logic [CW-1:0] cnt;
    logic          running;

    logic [VW:0]   rem_shift;  // remainder widened by one bit before the compare
    logic [VW-1:0] rem_sub;
    logic          fits;

    always_comb begin
        rem_shift = {rem, shreg[DW-1]};
        fits      = (rem_shift >= {1'b0, dvs});
        // When fits is set the difference is below 2^VW, so VW bits hold it exactly.
        rem_sub   = rem_shift[VW-1:0] - dvs;
        done      = running && (cnt == CW'(DW - 1));
    end

    assign quotient = shreg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem     <= '0;
            dvs     <= '0;
            shreg   <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            rem     <= '0;
            dvs     <= divisor;
            shreg   <= dividend;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            rem     <= fits ? rem_sub : rem_shift[VW-1:0];
            shreg   <= {shreg[DW-2:0], fits};
            cnt     <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/physics_div_arbiter.sv
// physics_div_arbiter: round-robin front end that shares one sequential
// restoring divider between NREQ physics requesters, with sign handling.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   req          - per-requester level request
//   dividend_in  - requester i signed dividend at [i*DW +: DW]
//   divisor_in   - requester i unsigned divisor at [i*VW +: VW]
//   grant        - one-hot, one cycle, request accepted (operands sampled)
//   done         - one-hot, one cycle, result for that requester valid
//   quotient     - signed quotient, truncated toward zero, 0 outside done
//   div_zero     - qualifies done: divisor was zero (quotient forced to 0)
//   busy         - high from the grant cycle through the done cycle
//   fsm_state    - current FSM state (physics_pkg::state_t encoding)
//
// Handshake: a requester raises req and holds it until it sees grant; its
// operands are captured at the edge that raises grant and may change freely
// afterwards. The result is presented for exactly one cycle with done. A req
// still high when the block is back in IDLE (the done cycle's closing edge)
// is treated as a new request.
module physics_div_arbiter
    import physics_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int VW   = DEF_VW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] dividend_in,
    input  logic [NREQ*VW-1:0] divisor_in,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [DW-1:0]     quotient,
    output logic              div_zero,
    output logic              busy,
    output logic [1:0]        fsm_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  idx;
    logic [DW-1:0]  op_dividend;
    logic [VW-1:0]  op_divisor;
    logic           neg;
    logic           zero_div;

    logic [IW-1:0]  win;
    logic [IW-1:0]  cand;
    logic           found;
    logic [DW:0]    ext;
    logic [DW:0]    mag_full;
    logic [DW-1:0]  mag;
    logic           unused_mag_top;
    logic           div_start;
    logic           div_last;
    logic [DW-1:0]  div_q;

    assign fsm_state = state;

    // Round robin: first requester at or after ptr, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Magnitude is negated in DW+1 bits so that -2^(DW-1) yields +2^(DW-1);
    // the top bit of the widened magnitude is then always zero.
    always_comb begin
        ext            = {op_dividend[DW-1], op_dividend};
        mag_full       = op_dividend[DW-1] ? (~ext + 1'b1) : ext;
        mag            = mag_full[DW-1:0];
        unused_mag_top = mag_full[DW];
    end

    assign div_start = (state == ST_LOAD) && (op_divisor != '0);

    seq_restoring_divider #(
        .DW (DW),
        .VW (VW)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (mag),
        .divisor  (op_divisor),
        .done     (div_last),
        .quotient (div_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            idx         <= '0;
            op_dividend <= '0;
            op_divisor  <= '0;
            neg         <= 1'b0;
            zero_div    <= 1'b0;
            grant       <= '0;
            done        <= '0;
            quotient    <= '0;
            div_zero    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            grant    <= '0;
            done     <= '0;
            quotient <= '0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant       <= NREQ'(1) << win;
                        idx         <= win;
                        op_dividend <= dividend_in[int'(win)*DW +: DW];
                        op_divisor  <= divisor_in[int'(win)*VW +: VW];
                        ptr         <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_LOAD;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    neg      <= op_dividend[DW-1];
                    zero_div <= (op_divisor == '0);
                    state    <= (op_divisor == '0) ? ST_DONE : ST_DIV;
                end
                ST_DIV: begin
                    if (div_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // done is raised here so the pulse lands in the IDLE
                    // cycle that also arbitrates the next request.
                    done     <= NREQ'(1) << idx;
                    div_zero <= zero_div;
                    quotient <= zero_div ? '0 : (neg ? (~div_q + 1'b1) : div_q);
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_physics_div_arbiter.sv
module tb_physics_div_arbiter;
  import physics_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 48;
  localparam int VW   = 32;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] dividend_in;
  logic [NREQ*VW-1:0] divisor_in;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      quotient;
  logic               div_zero;
  logic               busy;
  logic [1:0]         fsm_state;

  int checks = 0;
  int errors = 0;

  physics_div_arbiter #(.NREQ(NREQ), .DW(DW), .VW(VW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .grant       (grant),
    .done        (done),
    .quotient    (quotient),
    .div_zero    (div_zero),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // grant/done must never overlap and must each be one-hot or zero
  always @(negedge clock) begin
    if (!reset) begin
      if ((grant != 0) && (done != 0)) begin
        errors++;
        $display("FAIL grant_done_overlap: grant=%b done=%b expected one of them 0", grant, done);
      end
      if ((grant & (grant - 1'b1)) != 0) begin
        errors++;
        $display("FAIL grant_onehot: grant=%b expected one-hot", grant);
      end
      if ((done & (done - 1'b1)) != 0) begin
        errors++;
        $display("FAIL done_onehot: done=%b expected one-hot", done);
      end
    end
  end

  // driver tasks
  task automatic set_op(input int r, input logic [DW-1:0] d, input logic [VW-1:0] v);
    dividend_in[r*DW +: DW] = d;
    divisor_in[r*VW +: VW]  = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // cycles from call to first grant; -1 if budget expires
  task automatic wait_grant(input int budget, output int cyc, output logic [NREQ-1:0] g);
    cyc = -1;
    g   = '0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clock);
      #1;
      if (grant != 0) begin
        cyc = n;
        g   = grant;
        break;
      end
    end
  endtask

  // cycles from call to first done; -1 if budget expires
  task automatic wait_done(input int budget, output int cyc, output logic [NREQ-1:0] d,
                           output logic [DW-1:0] q, output logic z);
    cyc = -1;
    d   = '0;
    q   = '0;
    z   = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clock);
      #1;
      if (done != 0) begin
        cyc = n;
        d   = done;
        q   = quotient;
        z   = div_zero;
        break;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset       = 1'b1;
    req         = '0;
    dividend_in = '0;
    divisor_in  = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (grant !== '0) begin errors++; $display("FAIL rst_grant: got %b expected 0", grant); end
    checks++; if (done !== '0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL rst_quotient: got %h expected 0", quotient); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL rst_div_zero: got %b expected 0", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (fsm_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", fsm_state); end
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0 || fsm_state !== ST_IDLE) begin errors++; $display("FAIL rst_idle_after: busy=%b state=%0d expected 0/0", busy, fsm_state); end
  endtask

  task automatic test_positive();
    int cyc;
    logic [NREQ-1:0] g, d;
    logic [DW-1:0] q;
    logic z;
    set_op(0, 48'h00000000FF00, 32'd4);
    req = 4'b0001;
    wait_grant(5, cyc, g);
    req = '0;
    checks++; if (cyc !== 1) begin errors++; $display("FAIL pos_grant_lat: got %0d expected 1", cyc); end
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL pos_grant: got %b expected 0001", g); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pos_busy: got %b expected 1", busy); end
    wait_done(80, cyc, d, q, z);
    checks++; if (cyc !== 50) begin errors++; $display("FAIL pos_done_lat: got %0d expected 50", cyc); end
    checks++; if (d !== 4'b0001) begin errors++; $display("FAIL pos_done: got %b expected 0001", d); end
    checks++; if (q !== 48'h000000003FC0) begin errors++; $display("FAIL pos_quotient: got %h expected 000000003fc0", q); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL pos_div_zero: got %b expected 0", z); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pos_busy_done: got %b expected 1", busy); end
    @(posedge clock);
    #1;
    checks++; if (quotient !== '0 || done !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL pos_after: quotient=%h done=%b busy=%b expected 0/0/0", quotient, done, busy);
    end
  endtask

  task automatic test_negative();
    int cyc;
    logic [NREQ-1:0] g, d;
    logic [DW-1:0] q;
    logic z;
    set_op(1, 48'hFFFFFFFF0100, 32'd3);   // -65280 / 3
    req = 4'b0010;
    wait_grant(5, cyc, g);
    req = '0;
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL neg_grant: got %b expected 0010", g); end
    wait_done(80, cyc, d, q, z);
    checks++; if (d !== 4'b0010) begin errors++; $display("FAIL neg_done: got %b expected 0010", d); end
    checks++; if (q !== 48'hFFFFFFFFAB00) begin errors++; $display("FAIL neg_quotient: got %h expected ffffffffab00", q); end
  endtask

  task automatic test_truncation();
    int cyc;
    logic [NREQ-1:0] g, d;
    logic [DW-1:0] q;
    logic z;
    set_op(2, 48'hFFFFFFFFFFF9, 32'd2);   // -7 / 2 -> -3
    req = 4'b0100;
    wait_grant(5, cyc, g);
    req = '0;
    wait_done(80, cyc, d, q, z);
    checks++; if (d !== 4'b0100) begin errors++; $display("FAIL trunc_done: got %b expected 0100", d); end
    checks++; if (q !== 48'hFFFFFFFFFFFD) begin errors++; $display("FAIL trunc_quotient: got %h expected fffffffffffd", q); end
  endtask

  task automatic test_div_zero();
    int cyc;
    logic [NREQ-1:0] g, d;
    logic [DW-1:0] q;
    logic z;
    set_op(3, 48'd12345, 32'd0);
    req = 4'b1000;
    wait_grant(5, cyc, g);
    req = '0;
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL dz_grant: got %b expected 1000", g); end
    wait_done(10, cyc, d, q, z);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL dz_done_lat: got %0d expected 2", cyc); end
    checks++; if (d !== 4'b1000) begin errors++; $display("FAIL dz_done: got %b expected 1000", d); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", z); end
    checks++; if (q !== '0) begin errors++; $display("FAIL dz_quotient: got %h expected 0", q); end
    @(posedge clock);
    #1;
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_after: got %b expected 0", div_zero); end
  endtask

  task automatic test_round_robin();
    int cyc;
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] exp_a [5];
    logic [NREQ-1:0] exp_b [3];
    exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_b = '{4'b0100, 4'b0001, 4'b0100};
    do_reset();
    for (int r = 0; r < NREQ; r++) set_op(r, 48'd1, 32'd0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(10, cyc, g);
      checks++; if (g !== exp_a[i]) begin errors++; $display("FAIL rr_all_%0d: got %b expected %b", i, g, exp_a[i]); end
    end
    req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      wait_grant(10, cyc, g);
      checks++; if (g !== exp_b[i]) begin errors++; $display("FAIL rr_0101_%0d: got %b expected %b", i, g, exp_b[i]); end
    end
    req = '0;
    repeat (5) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [NREQ-1:0] g, d;
    logic [DW-1:0] q;
    logic z;
    set_op(2, 48'd1000000, 32'd7);
    req = 4'b0100;
    wait_grant(5, cyc, g);
    repeat (21) @(posedge clock);
    #1;
    checks++; if (fsm_state !== ST_DIV) begin errors++; $display("FAIL rm_in_div: state=%0d expected 2", fsm_state); end
    reset = 1'b1;
    #1;
    checks++; if (grant !== '0 || done !== '0 || quotient !== '0 || div_zero !== 1'b0 || busy !== 1'b0 || fsm_state !== ST_IDLE) begin
      errors++;
      $display("FAIL rm_async_clear: grant=%b done=%b q=%h dz=%b busy=%b state=%0d expected all 0",
               grant, done, quotient, div_zero, busy, fsm_state);
    end
    @(posedge clock);
    #1;
    checks++; if (done !== '0) begin errors++; $display("FAIL rm_no_done: got %b expected 0", done); end
    reset = 1'b0;
    wait_grant(5, cyc, g);
    req = '0;
    checks++; if (cyc !== 1) begin errors++; $display("FAIL rm_regrant_lat: got %0d expected 1", cyc); end
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL rm_regrant: got %b expected 0100", g); end
    wait_done(80, cyc, d, q, z);
    checks++; if (cyc !== 50) begin errors++; $display("FAIL rm_done_lat: got %0d expected 50", cyc); end
    checks++; if (q !== 48'd142857) begin errors++; $display("FAIL rm_quotient: got %0d expected 142857", q); end
  endtask

  task automatic test_operand_change();
    int cyc;
    logic [NREQ-1:0] g, d;
    logic [DW-1:0] q;
    logic z;
    set_op(0, 48'd1000, 32'd10);
    req = 4'b0001;
    wait_grant(5, cyc, g);
    req = '0;
    @(posedge clock);
    #1;
    set_op(0, 48'd5000, 32'd1);
    wait_done(80, cyc, d, q, z);
    checks++; if (d !== 4'b0001) begin errors++; $display("FAIL opc_done: got %b expected 0001", d); end
    checks++; if (q !== 48'd100) begin errors++; $display("FAIL opc_quotient: got %0d expected 100", q); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [NREQ-1:0] g, d;
    logic [DW-1:0] q;
    logic z;
    do_reset();
    set_op(0, 48'd100, 32'd5);
    set_op(1, 48'hFFFFFFFFFF9C, 32'd5);   // -100
    req = 4'b0011;
    wait_grant(5, cyc, g);
    req[0] = 1'b0;
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL b2b_grant0: got %b expected 0001", g); end
    wait_done(80, cyc, d, q, z);
    checks++; if (q !== 48'd20 || d !== 4'b0001) begin errors++; $display("FAIL b2b_result0: got %h/%b expected 14/0001", q, d); end
    // next grant lands the cycle after done: DW+3 cycles grant to grant
    wait_grant(5, cyc, g);
    req[1] = 1'b0;
    checks++; if (cyc !== 1) begin errors++; $display("FAIL b2b_gap: got %0d expected 1", cyc); end
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL b2b_grant1: got %b expected 0010", g); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    wait_done(80, cyc, d, q, z);
    checks++; if (q !== 48'hFFFFFFFFFFEC || d !== 4'b0010) begin errors++; $display("FAIL b2b_result1: got %h/%b expected ffffffffffec/0010", q, d); end
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_truncation();
    test_div_zero();
    test_round_robin();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
